vmicro16_wb_regs: RTL and testbench

//   Wishbone classic slave register bank on the SoC internal bus, downstream of the

---
 rtl/vmicro16_wb_regs.sv | 143 ++++++++++++++
 tb/tb_vmicro16_wb_regs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_wb_regs.sv
// Wishbone classic slave holding NUM_REGS 16-bit registers at BASE_ADDR.
// Optional wait states delay the ack; accesses outside the window are still acked.
module vmicro16_wb_regs #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_addr_i,
    input  logic [15:0] wb_data_i,
    output logic [15:0] wb_data_o,
    output logic        wb_ack_o
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam logic [3:0] CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          hit_q, hit_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ack_q;
    logic [15:0]   regs_q [NUM_REGS];

    logic          req;
    logic          addr_hit;
    logic          enter_ack;
    logic          cur_we;
    logic          cur_hit;
    logic [AW-1:0] cur_idx;
    logic [15:0]   cur_data;

    assign req      = wb_cyc_i & wb_stb_i;
    assign addr_hit = (wb_addr_i[15:AW] == BASE_ADDR[15:AW]);

    // With no wait states the commit happens straight from IDLE, so use live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            cur_we   = wb_we_i;
            cur_hit  = addr_hit;
            cur_idx  = wb_addr_i[AW-1:0];
            cur_data = wb_data_i;
        end else begin
            cur_we   = we_q;
            cur_hit  = hit_q;
            cur_idx  = idx_q;
            cur_data = wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        enter_ack = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = wb_we_i;
                    hit_d   = addr_hit;
                    idx_d   = wb_addr_i[AW-1:0];
                    wdata_d = wb_data_i;
                    if (WAIT_STATES == 0) begin
                        state_d   = StAck;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = 16'h0000;
        if (enter_ack && cur_hit && !cur_we) begin
            rdata_d = regs_q[cur_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= enter_ack;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (enter_ack && cur_hit && cur_we) begin
            regs_q[cur_idx] <= cur_data;
        end
    end

    assign wb_data_o = rdata_q;
    assign wb_ack_o  = ack_q;

endmodule

// File: tb/tb_vmicro16_wb_regs.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
// Shared clock/reset; each instance has its own bus signals.
module tb_vmicro16_wb_regs;

    localparam logic [15:0] Base0 = 16'h0040;
    localparam logic [15:0] Base1 = 16'h0100;

    logic        clk;
    logic        reset;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [15:0] addr [2];
    logic [15:0] din  [2];
    logic [15:0] dout [2];
    logic        ack  [2];

    int n_tests;
    int n_fail;

    logic [15:0] model [8];
    logic [15:0] rd;
    int          lat;

    vmicro16_wb_regs #(.BASE_ADDR(Base0), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .wb_cyc_i  (cyc[0]),
        .wb_stb_i  (stb[0]),
        .wb_we_i   (we[0]),
        .wb_addr_i (addr[0]),
        .wb_data_i (din[0]),
        .wb_data_o (dout[0]),
        .wb_ack_o  (ack[0])
    );

    vmicro16_wb_regs #(.BASE_ADDR(Base1), .NUM_REGS(8), .WAIT_STATES(3)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .wb_cyc_i  (cyc[1]),
        .wb_stb_i  (stb[1]),
        .wb_we_i   (we[1]),
        .wb_addr_i (addr[1]),
        .wb_data_i (din[1]),
        .wb_data_o (dout[1]),
        .wb_ack_o  (ack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; lat = posedges until ack seen (0 on timeout).
    task automatic xfer(input int sel, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] r, output int l);
        logic done;
        cyc[sel]  = 1'b1;
        stb[sel]  = 1'b1;
        we[sel]   = w;
        addr[sel] = a;
        din[sel]  = d;
        l    = 0;
        r    = 16'hxxxx;
        done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!done) begin
                @(negedge clk);
                if (ack[sel]) begin
                    l    = i;
                    r    = dout[sel];
                    done = 1'b1;
                end
            end
        end
        cyc[sel] = 1'b0;
        stb[sel] = 1'b0;
        we[sel]  = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all0(input string tag);
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, Base0 + 16'(i), 16'h0000, rd, lat);
            check(tag, {16'h0000, rd}, {16'h0000, model[i]});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        for (int s = 0; s < 2; s++) begin
            cyc[s] = 1'b0; stb[s] = 1'b0; we[s] = 1'b0; addr[s] = 16'h0; din[s] = 16'h0;
        end
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("rst_ack0", {31'd0, ack[0]}, 32'd0);
        check("rst_dout0", {16'h0, dout[0]}, 32'd0);
        check("rst_ack1", {31'd0, ack[1]}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // All registers read zero after reset
        check_all0("rd_after_rst");

        // Write then read BASE+3
        xfer(0, 1'b1, Base0 + 16'd3, 16'h1234, rd, lat);
        model[3] = 16'h1234;
        check("wr_lat", lat, 1);
        xfer(0, 1'b0, Base0 + 16'd3, 16'h0000, rd, lat);
        check("rd_lat", lat, 1);
        check("rd_1234", {16'h0, rd}, 32'h1234);
        check("dout_idle0", {16'h0, dout[0]}, 32'd0);

        // Boundary indices, neighbours unchanged
        xfer(0, 1'b1, Base0, 16'hFFFF, rd, lat);
        model[0] = 16'hFFFF;
        xfer(0, 1'b1, Base0 + 16'd7, 16'hA5A5, rd, lat);
        model[7] = 16'hA5A5;
        check_all0("rd_bounds");

        // Miss: acked, reads zero, nothing modified
        xfer(0, 1'b1, Base0 + 16'd8, 16'hDEAD, rd, lat);
        check("miss_wr_lat", lat, 1);
        xfer(0, 1'b0, Base0 + 16'd8, 16'h0000, rd, lat);
        check("miss_rd_lat", lat, 1);
        check("miss_rd", {16'h0, rd}, 32'd0);
        xfer(0, 1'b0, Base0 - 16'd1, 16'h0000, rd, lat);
        check("miss_below_rd", {16'h0, rd}, 32'd0);
        check_all0("rd_after_miss");

        // Back-to-back with stb held: ack, idle, ack, idle, ack
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = Base0 + 16'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2b_ack", {31'd0, ack[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check("b2b_data", {16'h0, dout[0]}, 32'hA5A5);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        check("b2b_end", {31'd0, ack[0]}, 32'd0);

        // Wait states: write and read latency E0+4
        xfer(1, 1'b1, Base1 + 16'd1, 16'hC0DE, rd, lat);
        check("ws_wr_lat", lat, 4);
        xfer(1, 1'b0, Base1 + 16'd1, 16'h0000, rd, lat);
        check("ws_rd_lat", lat, 4);
        check("ws_rd", {16'h0, rd}, 32'hC0DE);

        // Abort in WAIT: no ack, no commit
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = Base1 + 16'd2; din[1] = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_noack", {31'd0, ack[1]}, 32'd0);
        end
        xfer(1, 1'b0, Base1 + 16'd2, 16'h0000, rd, lat);
        check("abort_lat", lat, 4);
        check("abort_nowr", {16'h0, rd}, 32'd0);

        // Reset during WAIT of a write
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = Base1 + 16'd5; din[1] = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_ack", {31'd0, ack[1]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ack_after", {31'd0, ack[1]}, 32'd0);
        xfer(1, 1'b0, Base1 + 16'd5, 16'h0000, rd, lat);
        check("rst_mid_nowr", {16'h0, rd}, 32'd0);
        xfer(1, 1'b0, Base1 + 16'd1, 16'h0000, rd, lat);
        check("rst_mid_clr1", {16'h0, rd}, 32'd0);
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        check_all0("rst_clr0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
